// File: rtl/flash_bus_sched_if.sv
// Signal bundle between the flash bus scheduler and the flash controller, PFL
// and FPGA configuration pins.
interface flash_bus_sched_if;
  logic       fc_req;
  logic       fc_done;
  logic [1:0] fc_page;
  logic       pfl_req;
  logic       reconf_req;
  logic       fpga_conf_done;
  logic       grant_fc;
  logic       grant_pfl;
  logic       pfl_nreset;
  logic       pfl_nreconfigure;
  logic [2:0] fpga_pgm;
  logic       cfg_ok;
  logic       cfg_fail;
  logic [3:0] state_dbg;

  modport slave (
    input  fc_req, fc_done, fc_page, pfl_req, reconf_req, fpga_conf_done,
    output grant_fc, grant_pfl, pfl_nreset, pfl_nreconfigure, fpga_pgm,
           cfg_ok, cfg_fail, state_dbg
  );

  modport master (
    output fc_req, fc_done, fc_page, pfl_req, reconf_req, fpga_conf_done,
    input  grant_fc, grant_pfl, pfl_nreset, pfl_nreconfigure, fpga_pgm,
           cfg_ok, cfg_fail, state_dbg
  );
endinterface

// File: rtl/flash_bus_sched.sv
// CFI flash bus arbiter: boots via the flash controller, sequences PFL
// reset/reconfiguration with timeout + factory fallback, then arbitrates.
module flash_bus_sched #(
  parameter int unsigned       TURN_CYC     = 4,
  parameter int unsigned       NRST_CYC     = 8,
  parameter int unsigned       NRECONF_CYC  = 16,
  parameter int unsigned       TMO_W        = 24,
  parameter logic [TMO_W-1:0]  CFG_TMO      = 24'hFFFFFF,
  parameter logic [1:0]        FACTORY_PAGE = 2'b00
) (
  input logic               clkin_max_100,
  input logic               sys_resetn,
  flash_bus_sched_if.slave  bus
);

  typedef enum logic [3:0] {
    IDLE = 4'd0, FC_BOOT = 4'd1, TURN = 4'd2, PFL_RST = 4'd3, PFL_RECFG = 4'd4,
    CFG_WAIT = 4'd5, FALLBACK = 4'd6, PFL_HOLD = 4'd7, PARK = 4'd8, FC_RUN = 4'd9
  } state_t;

  state_t            state_reg, state_next, target_reg, target_next;
  logic [3:0]        async_in, sync1_reg, sync2_reg;
  logic              reconf_d_reg, reconf_edge;
  logic [7:0]        cnt_reg, cnt_next;
  logic [TMO_W-1:0]  tmr_reg, tmr_next;
  logic [1:0]        page_reg, page_next, latched_page;
  logic              retry_reg, retry_next, pend_reg, pend_next;
  logic              ok_reg, ok_next, fail_reg, fail_next;
  logic              grant_fc_reg, grant_fc_next, grant_pfl_reg, grant_pfl_next;
  logic              nrst_reg, nrst_next, nrecfg_reg, nrecfg_next;
  logic              fc_req_s, fc_done_s, reconf_s, conf_s;

  assign async_in     = {bus.fpga_conf_done, bus.reconf_req, bus.fc_done, bus.fc_req};
  assign fc_req_s     = sync2_reg[0];
  assign fc_done_s    = sync2_reg[1];
  assign reconf_s     = sync2_reg[2];
  assign conf_s       = sync2_reg[3];
  assign reconf_edge  = reconf_s & ~reconf_d_reg;
  // Page 3 is not a valid image slot; it falls back to the factory image.
  assign latched_page = (bus.fc_page == 2'b11) ? FACTORY_PAGE : bus.fc_page;

  always_ff @(posedge clkin_max_100 or negedge sys_resetn) begin
    if (!sys_resetn) begin
      state_reg     <= IDLE;
      target_reg    <= IDLE;
      sync1_reg     <= '0;
      sync2_reg     <= '0;
      reconf_d_reg  <= 1'b0;
      cnt_reg       <= '0;
      tmr_reg       <= '0;
      page_reg      <= 2'b00;
      retry_reg     <= 1'b0;
      pend_reg      <= 1'b0;
      ok_reg        <= 1'b0;
      fail_reg      <= 1'b0;
      grant_fc_reg  <= 1'b0;
      grant_pfl_reg <= 1'b0;
      nrst_reg      <= 1'b0;
      nrecfg_reg    <= 1'b1;
    end else begin
      state_reg     <= state_next;
      target_reg    <= target_next;
      sync1_reg     <= async_in;
      sync2_reg     <= sync1_reg;
      reconf_d_reg  <= reconf_s;
      cnt_reg       <= cnt_next;
      tmr_reg       <= tmr_next;
      page_reg      <= page_next;
      retry_reg     <= retry_next;
      pend_reg      <= pend_next;
      ok_reg        <= ok_next;
      fail_reg      <= fail_next;
      grant_fc_reg  <= grant_fc_next;
      grant_pfl_reg <= grant_pfl_next;
      nrst_reg      <= nrst_next;
      nrecfg_reg    <= nrecfg_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    target_next = target_reg;
    page_next   = page_reg;
    retry_next  = retry_reg;
    ok_next     = ok_reg;
    fail_next   = fail_reg;
    pend_next   = pend_reg | reconf_edge;
    case (state_reg)
      IDLE: state_next = FC_BOOT;
      FC_BOOT: begin
        if (fc_done_s) begin
          page_next   = latched_page;
          retry_next  = 1'b0;
          target_next = PFL_RST;
          state_next  = TURN;
        end
      end
      TURN:      if (cnt_reg == 8'(TURN_CYC - 1))    state_next = target_reg;
      PFL_RST:   if (cnt_reg == 8'(NRST_CYC - 1))    state_next = PFL_RECFG;
      PFL_RECFG: if (cnt_reg == 8'(NRECONF_CYC - 1)) state_next = CFG_WAIT;
      CFG_WAIT: begin
        if (conf_s) begin
          ok_next    = 1'b1;
          state_next = PFL_HOLD;
        end else if (tmr_reg == CFG_TMO - 1'b1) begin
          if (!retry_reg && page_reg != FACTORY_PAGE) begin
            state_next = FALLBACK;
          end else begin
            fail_next   = 1'b1;
            target_next = PARK;
            state_next  = TURN;
          end
        end
      end
      FALLBACK: begin
        page_next  = FACTORY_PAGE;
        retry_next = 1'b1;
        state_next = PFL_RST;
      end
      PFL_HOLD: begin
        if (!bus.pfl_req) begin
          target_next = PARK;
          state_next  = TURN;
        end
      end
      PARK: begin
        // Bus is already idle here, so owners are granted without a TURN.
        if (pend_reg || reconf_edge) begin
          page_next  = latched_page;
          retry_next = 1'b0;
          pend_next  = 1'b0;
          state_next = PFL_RST;
        end else if (bus.pfl_req) begin
          state_next = PFL_HOLD;
        end else if (fc_req_s) begin
          state_next = FC_RUN;
        end
      end
      FC_RUN: begin
        if (!fc_req_s) begin
          target_next = PARK;
          state_next  = TURN;
        end
      end
      default: state_next = IDLE;
    endcase

    if (state_next == PFL_RST) begin
      ok_next   = 1'b0;
      fail_next = 1'b0;
    end

    // Outputs are registered from the next state so they change with state_dbg.
    grant_fc_next  = (state_next == FC_BOOT) || (state_next == FC_RUN);
    grant_pfl_next = (state_next == PFL_RST) || (state_next == PFL_RECFG) ||
                     (state_next == CFG_WAIT) || (state_next == FALLBACK) ||
                     (state_next == PFL_HOLD);
    nrecfg_next    = (state_next != PFL_RECFG);
    nrst_next      = nrst_reg;
    if (state_next == PFL_RST)   nrst_next = 1'b0;
    if (state_next == PFL_RECFG) nrst_next = 1'b1;

    cnt_next = (cnt_reg == 8'hFF) ? cnt_reg : cnt_reg + 8'd1;
    if (state_next != state_reg) cnt_next = '0;

    tmr_next = tmr_reg;
    if (state_next == PFL_RECFG) tmr_next = '0;
    else if (state_reg == CFG_WAIT && tmr_reg != '1) tmr_next = tmr_reg + 1'b1;
  end

  assign bus.grant_fc         = grant_fc_reg;
  assign bus.grant_pfl        = grant_pfl_reg;
  assign bus.pfl_nreset       = nrst_reg;
  assign bus.pfl_nreconfigure = nrecfg_reg;
  assign bus.fpga_pgm         = {1'b0, page_reg};
  assign bus.cfg_ok           = ok_reg;
  assign bus.cfg_fail         = fail_reg;
  assign bus.state_dbg        = state_reg;

endmodule

// File: tb/tb_flash_bus_sched.sv
// Scoreboard bench: stimulus predicts each state entry (cycle and outputs),
// a negedge monitor pops and compares on every state_dbg change.
module tb_flash_bus_sched;
  localparam int         TURN = 4, NRST = 8, NREC = 16, TMO = 1000;
  localparam logic [1:0] FACT = 2'b00;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0, errors = 0;

  flash_bus_sched_if bus();

  flash_bus_sched #(
    .TURN_CYC(TURN), .NRST_CYC(NRST), .NRECONF_CYC(NREC),
    .TMO_W(24), .CFG_TMO(24'd1000), .FACTORY_PAGE(FACT)
  ) dut (
    .clkin_max_100(clk),
    .sys_resetn(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [3:0]  st;
    logic [12:0] vec;
    int          at;
  } exp_t;

  exp_t        q[$];
  logic [1:0]  m_page = 2'b00;
  logic        m_ok = 1'b0, m_fail = 1'b0, m_nrst = 1'b0;

  function automatic logic [1:0] grants_of(input logic [3:0] s);
    if (s == 4'd1 || s == 4'd9) return 2'b10;
    if (s >= 4'd3 && s <= 4'd7) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [1:0] lat(input logic [1:0] p);
    return (p == 2'b11) ? FACT : p;
  endfunction

  task automatic push(input logic [3:0] s, input int at);
    exp_t e;
    if (s == 4'd3) m_nrst = 1'b0;
    if (s == 4'd4) m_nrst = 1'b1;
    e.st  = s;
    e.vec = {s, grants_of(s), m_nrst, (s != 4'd4), 1'b0, m_page, m_ok, m_fail};
    e.at  = at;
    q.push_back(e);
  endtask

  // Monitor: per-cycle grant/strobe consistency plus scoreboard on state entry.
  logic [3:0]  prev_st = 4'd0;
  logic [12:0] mon_act;
  exp_t        mon_e;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_st = 4'd0;
    end else begin
      checks++;
      if ({bus.grant_fc, bus.grant_pfl, bus.pfl_nreconfigure} !==
          {grants_of(bus.state_dbg), (bus.state_dbg != 4'd4)} ||
          (bus.state_dbg == 4'd3 && bus.pfl_nreset !== 1'b0)) begin
        errors++;
        $display("FAIL cycle_outputs cyc=%0d st=%0d actual gfc=%b gpfl=%b nrst=%b nrecfg=%b required grants=%b",
                 cyc, bus.state_dbg, bus.grant_fc, bus.grant_pfl, bus.pfl_nreset,
                 bus.pfl_nreconfigure, grants_of(bus.state_dbg));
      end
      if (bus.state_dbg !== prev_st) begin
        checks++;
        mon_act = {bus.state_dbg, bus.grant_fc, bus.grant_pfl, bus.pfl_nreset,
                   bus.pfl_nreconfigure, bus.fpga_pgm, bus.cfg_ok, bus.cfg_fail};
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_entry cyc=%0d actual st=%0d required no transition", cyc, bus.state_dbg);
        end else begin
          mon_e = q.pop_front();
          if (mon_act !== mon_e.vec || cyc != mon_e.at) begin
            errors++;
            $display("FAIL entry_st%0d actual vec=%h cyc=%0d required vec=%h cyc=%0d",
                     mon_e.st, mon_act, cyc, mon_e.vec, mon_e.at);
          end else begin
            $display("entry st=%0d cyc=%0d pgm=%0d ok=%b fail=%b", bus.state_dbg, cyc,
                     bus.fpga_pgm, bus.cfg_ok, bus.cfg_fail);
          end
        end
        prev_st = bus.state_dbg;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic drain(input int budget);
    int i = 0;
    while (q.size() != 0 && i < budget) begin
      tick();
      i++;
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout actual pending=%0d (next st=%0d) required pending=0", q.size(), q[0].st);
      q.delete();
    end
  endtask

  task automatic check_reset(input string tag);
    logic [12:0] a;
    a = {bus.state_dbg, bus.grant_fc, bus.grant_pfl, bus.pfl_nreset,
         bus.pfl_nreconfigure, bus.fpga_pgm, bus.cfg_ok, bus.cfg_fail};
    checks++;
    if (a !== 13'h020) begin
      errors++;
      $display("FAIL %s actual vec=%h required vec=%h", tag, a, 13'h020);
    end else begin
      $display("%s outputs at reset values", tag);
    end
  endtask

  // Configuration sequence starting with PFL_RST entry at cycle t; ends in PARK.
  task automatic cfg_seq(input int t, input bit success);
    int w, n;
    m_ok = 1'b0;
    m_fail = 1'b0;
    push(4'd3, t);
    push(4'd4, t + NRST);
    push(4'd5, t + NRST + NREC);
    if (success) begin
      drain(200);
      bus.pfl_req = 1'b1;
      repeat ($urandom_range(0, 40)) tick();
      bus.fpga_conf_done = 1'b1;
      n = cyc;
      m_ok = 1'b1;
      push(4'd7, n + 3);
      drain(20);
      bus.fpga_conf_done = 1'b0;
      repeat ($urandom_range(1, 30)) tick();
      bus.pfl_req = 1'b0;
      n = cyc;
      push(4'd2, n + 1);
      push(4'd8, n + 1 + TURN);
      drain(30);
    end else begin
      w = t + NRST + NREC;
      if (m_page != FACT) begin
        push(4'd6, w + TMO);
        m_page = FACT;
        push(4'd3, w + TMO + 1);
        push(4'd4, w + TMO + 1 + NRST);
        push(4'd5, w + TMO + 1 + NRST + NREC);
        w = w + TMO + 1 + NRST + NREC;
      end
      m_fail = 1'b1;
      push(4'd2, w + TMO);
      push(4'd8, w + TMO + TURN);
      drain(3000);
    end
  endtask

  task automatic reconf_park(input logic [1:0] p, input bit success);
    int n;
    bus.fc_page = p;
    bus.reconf_req = 1'b1;
    n = cyc;
    m_page = lat(p);
    cfg_seq(n + 3, success);
    bus.reconf_req = 1'b0;
    repeat (4) tick();
  endtask

  task automatic arb(input int kind);
    int n;
    if (kind == 0) begin
      bus.pfl_req = 1'b1;
      n = cyc;
      push(4'd7, n + 1);
      drain(10);
      repeat ($urandom_range(0, 15)) tick();
      bus.pfl_req = 1'b0;
      n = cyc;
      push(4'd2, n + 1);
      push(4'd8, n + 1 + TURN);
    end else if (kind == 1) begin
      bus.fc_req = 1'b1;
      n = cyc;
      push(4'd9, n + 3);
      drain(10);
      repeat ($urandom_range(0, 15)) tick();
      bus.fc_req = 1'b0;
      n = cyc;
      push(4'd2, n + 3);
      push(4'd8, n + 3 + TURN);
    end else if (kind == 2) begin
      bus.fc_req = 1'b1;
      bus.pfl_req = 1'b1;
      n = cyc;
      push(4'd7, n + 1);
      drain(10);
      repeat ($urandom_range(0, 15)) tick();
      bus.pfl_req = 1'b0;
      n = cyc;
      push(4'd2, n + 1);
      push(4'd8, n + 1 + TURN);
      push(4'd9, n + 2 + TURN);
      drain(20);
      repeat ($urandom_range(0, 15)) tick();
      bus.fc_req = 1'b0;
      n = cyc;
      push(4'd2, n + 3);
      push(4'd8, n + 3 + TURN);
    end else begin
      bus.fc_req = 1'b1;
      n = cyc;
      tick();
      bus.fc_req = 1'b0;
      push(4'd9, n + 3);
      push(4'd2, n + 4);
      push(4'd8, n + 4 + TURN);
    end
    drain(30);
  endtask

  task automatic reconf_fcrun(input logic [1:0] p, input bit success);
    int n;
    bus.fc_req = 1'b1;
    n = cyc;
    push(4'd9, n + 3);
    drain(10);
    repeat (2) tick();
    bus.fc_page = p;
    bus.reconf_req = 1'b1;
    repeat (4) tick();
    bus.reconf_req = 1'b0;
    repeat ($urandom_range(0, 10)) tick();
    bus.fc_req = 1'b0;
    n = cyc;
    push(4'd2, n + 3);
    push(4'd8, n + 3 + TURN);
    m_page = lat(p);
    cfg_seq(n + 4 + TURN, success);
    repeat (4) tick();
  endtask

  initial begin
    int n;
    bus.fc_req = 1'b0;
    bus.fc_done = 1'b0;
    bus.fc_page = 2'b00;
    bus.pfl_req = 1'b0;
    bus.reconf_req = 1'b0;
    bus.fpga_conf_done = 1'b0;
    repeat (3) tick();
    check_reset("reset_init");

    // Boot: flash controller owns the bus until fc_done selects page 1.
    rst_n = 1'b1;
    n = cyc;
    push(4'd1, n + 1);
    repeat (19) tick();
    bus.fc_page = 2'b01;
    bus.fc_done = 1'b1;
    n = cyc;
    m_page = 2'b01;
    push(4'd2, n + 3);
    cfg_seq(n + 3 + TURN, 1'b1);

    arb(2);
    reconf_fcrun(2'b10, 1'b1);
    reconf_park(2'b10, 1'b0);

    for (int i = 0; i < 12; i++) begin
      int k;
      k = $urandom_range(0, 4);
      if (k < 4) arb(k);
      else reconf_park(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    // Asynchronous reset in the middle of CFG_WAIT.
    bus.fc_page = 2'($urandom_range(0, 3));
    bus.reconf_req = 1'b1;
    n = cyc;
    m_page = lat(bus.fc_page);
    m_ok = 1'b0;
    m_fail = 1'b0;
    push(4'd3, n + 3);
    push(4'd4, n + 3 + NRST);
    push(4'd5, n + 3 + NRST + NREC);
    drain(100);
    bus.reconf_req = 1'b0;
    repeat ($urandom_range(2, 50)) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check_reset("reset_mid_cfg_wait");
    repeat (2) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
